// File: rtl/ofm_requant_writer.sv
// ofm_requant_writer
// Takes signed convolution results, rounds and right-shifts them, saturates
// them to the output word width and writes them to the output-feature-map
// memory. Addresses come from col/row/ch counters in CHW or HWC order.
// Two-stage pipeline: stage 1 rounds/shifts and captures the address,
// stage 2 saturates and drives the memory write port.
module ofm_requant_writer #(
  parameter int DATA_WIDTH = 48,
  parameter int OUT_WIDTH  = 16,
  parameter int OFM_SIZE   = 64,
  parameter int CO         = 8,
  parameter int SHIFT      = 8,
  parameter int LAYOUT     = 0,
  localparam int ADDR_W    = $clog2(OFM_SIZE*OFM_SIZE*CO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [OUT_WIDTH-1:0]  wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sat_cnt,
  output logic                  err_overrun
);

  localparam int POS_W = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
  localparam int CH_W  = (CO > 1) ? $clog2(CO) : 1;
  localparam int EXT_W = DATA_WIDTH + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(OFM_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CO - 1);

  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [EXT_W-1:0] RND =
    (SHIFT > 0) ? (EXT_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : {EXT_W{1'b0}};
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Clip to the signed output range; MSB of the result flags a clip.
  function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [EXT_W-1:0] v);
    logic [OUT_WIDTH:0] r;
    if (v > SAT_MAX) begin
      r = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (v < SAT_MIN) begin
      r = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end else begin
      r = {1'b0, v[OUT_WIDTH-1:0]};
    end
    return r;
  endfunction

  logic [1:0]               state_r;
  logic [1:0]               state_next_s;
  logic [POS_W-1:0]         col_r;
  logic [POS_W-1:0]         row_r;
  logic [CH_W-1:0]          ch_r;
  logic                     s1_valid_r;
  logic signed [EXT_W-1:0]  s1_val_r;
  logic [ADDR_W-1:0]        s1_addr_r;
  logic signed [EXT_W-1:0]  ext_s;
  logic signed [EXT_W-1:0]  rnd_s;
  logic [ADDR_W-1:0]        addr_s;
  logic [OUT_WIDTH:0]       sat_s;
  logic                     accept_s;
  logic                     last_s;
  logic                     start_s;
  logic                     overrun_s;

  // Acceptance, last-sample, arming and overrun decode.
  always_comb begin
    start_s   = start && (state_r == ST_IDLE);
    accept_s  = in_valid && (state_r == ST_RUN);
    overrun_s = in_valid && (state_r != ST_RUN);
    last_s    = accept_s && (col_r == POS_LAST) && (row_r == POS_LAST) && (ch_r == CH_LAST);
  end

  // Stage-1 arithmetic: sign-extend, add rounding constant, arithmetic shift.
  always_comb begin
    ext_s = {in_data[DATA_WIDTH-1], in_data};
    rnd_s = (ext_s + RND) >>> SHIFT;
  end

  // Memory address from the counters as they stand when the sample is accepted.
  always_comb begin
    if (LAYOUT == 0) begin
      addr_s = ADDR_W'(ch_r) * ADDR_W'(OFM_SIZE*OFM_SIZE)
             + ADDR_W'(row_r) * ADDR_W'(OFM_SIZE) + ADDR_W'(col_r);
    end else begin
      addr_s = (ADDR_W'(row_r) * ADDR_W'(OFM_SIZE) + ADDR_W'(col_r)) * ADDR_W'(CO)
             + ADDR_W'(ch_r);
    end
  end

  // Stage-2 saturation of the registered stage-1 value.
  always_comb begin
    sat_s = sat_fn(s1_val_r);
  end

  // Next-state logic; the single FLUSH cycle moves the final sample into the
  // output register, so done rises together with the last write strobe.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_RUN;
        else       state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_next_s = ST_FLUSH;
        else        state_next_s = ST_RUN;
      end
      ST_FLUSH: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == ST_RUN) || (state_next_s == ST_FLUSH);
      done    <= (state_next_s == ST_DONE);
    end
  end

  // col/row/ch position counters, advanced once per accepted sample.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      col_r <= {POS_W{1'b0}};
      row_r <= {POS_W{1'b0}};
      ch_r  <= {CH_W{1'b0}};
    end else if (accept_s) begin
      if (col_r == POS_LAST) begin
        col_r <= {POS_W{1'b0}};
        if (row_r == POS_LAST) begin
          row_r <= {POS_W{1'b0}};
          ch_r  <= ch_r + CH_W'(1);
        end else begin
          row_r <= row_r + POS_W'(1);
        end
      end else begin
        col_r <= col_r + POS_W'(1);
      end
    end
  end

  // Stage-1 pipeline register: rounded value and its address travel together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_val_r   <= {EXT_W{1'b0}};
      s1_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_val_r  <= rnd_s;
        s1_addr_r <= addr_s;
      end
    end
  end

  // Stage-2 output register driving the memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= {ADDR_W{1'b0}};
      wr_data <= {OUT_WIDTH{1'b0}};
    end else begin
      wr_en <= s1_valid_r;
      if (s1_valid_r) begin
        wr_addr <= s1_addr_r;
        wr_data <= sat_s[OUT_WIDTH-1:0];
      end
    end
  end

  // Saturation counter (holds at all-ones) and sticky overrun flag, per layer.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      sat_cnt     <= 16'd0;
      err_overrun <= 1'b0;
    end else begin
      if (s1_valid_r && sat_s[OUT_WIDTH] && (sat_cnt != 16'hFFFF)) begin
        sat_cnt <= sat_cnt + 16'd1;
      end
      if (overrun_s) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofm_requant_writer.sv
// Testbench for ofm_requant_writer: directed stimulus with a write scoreboard.
module tb_ofm_requant_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [47:0] in_data;
  logic        wr_en, wr_en_h;
  logic [14:0] wr_addr, wr_addr_h;
  logic [15:0] wr_data, wr_data_h;
  logic        busy, busy_h, done, done_h, err_overrun, err_overrun_h;
  logic [15:0] sat_cnt, sat_cnt_h;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sat_exp = 0;
  int hwc_idx = 0;
  logic hwc_en = 1'b0;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  ofm_requant_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .sat_cnt(sat_cnt), .err_overrun(err_overrun)
  );

  ofm_requant_writer #(.LAYOUT(1)) dut_hwc (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_h), .wr_addr(wr_addr_h), .wr_data(wr_data_h), .busy(busy_h), .done(done_h),
    .sat_cnt(sat_cnt_h), .err_overrun(err_overrun_h)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference requantiser: round half up, shift by 8, clip to 16 bits.
  function automatic logic [16:0] ref_q(input logic [47:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 64'sd128) >>> 8;
    if (v > 64'sd32767) return {1'b1, 16'h7FFF};
    else if (v < -64'sd32768) return {1'b1, 16'h8000};
    else return {1'b0, v[15:0]};
  endfunction

  function automatic logic [47:0] rand_val(input int i);
    logic [31:0] r;
    longint v;
    r = $urandom;
    v = longint'($signed(r)) >>> (i % 24);
    return v[47:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_exp(input logic [47:0] x, input logic [14:0] addr,
                           input logic [15:0] d, input logic clip);
    exp_t e;
    in_data  = x;
    in_valid = 1'b1;
    e.addr = addr;
    e.data = d;
    e.due  = cyc + 2;
    sbq.push_back(e);
    if (clip) sat_exp++;
    step();
  endtask

  task automatic drive_sample(input logic [47:0] x, input logic [14:0] addr);
    logic [16:0] q;
    q = ref_q(x);
    drive_exp(x, addr, q[15:0], q[16]);
  endtask

  // Write monitor: every strobe must match the oldest expected entry on time.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wr_en", 64'(wr_en), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("wr_latency", 64'(cyc), 64'(e.due));
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      chk("missing_wr_en", 64'(wr_en), 64'(1));
      void'(sbq.pop_front());
    end
  end

  // HWC instance address check over the full layer.
  always @(negedge clk) begin
    if (hwc_en && wr_en_h === 1'b1) begin
      chk("hwc_addr", 64'(wr_addr_h), 64'((hwc_idx % 4096) * 8 + hwc_idx / 4096));
      if (hwc_idx == 64)   chk("hwc_addr_s64", 64'(wr_addr_h), 64'(512));
      if (hwc_idx == 4096) chk("hwc_addr_s4096", 64'(wr_addr_h), 64'(1));
      hwc_idx++;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 48'd0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    chk("rst_err_overrun", 64'(err_overrun), 64'(0));

    // Layer 1: directed rounding and saturation values with gaps in in_valid.
    start = 1'b1; step(); start = 1'b0;
    chk("busy_run", 64'(busy), 64'(1));
    drive_exp(48'h000000001280, 15'd0, 16'h0013, 1'b0);
    idle(1);
    drive_exp(48'h000001000000, 15'd1, 16'h7FFF, 1'b1);
    drive_exp(48'hFF0000000000, 15'd2, 16'h8000, 1'b1);
    idle(3);
    chk("sat_cnt_2", 64'(sat_cnt), 64'(2));
    chk("busy_gap", 64'(busy), 64'(1));

    // Continue to sample 100, then reset with samples in flight.
    for (int i = 3; i <= 100; i++) drive_sample(rand_val(i), 15'(i));
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    sbq.delete();
    rst = 1'b0;
    chk("abort_wr_en", 64'(wr_en), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_sat_cnt", 64'(sat_cnt), 64'(0));
    step();
    chk("abort_wr_en2", 64'(wr_en), 64'(0));
    chk("abort_done", 64'(done), 64'(0));

    // Fresh start after abort restarts at address 0.
    start = 1'b1; step(); start = 1'b0;
    drive_exp(48'h000000001280, 15'd0, 16'h0013, 1'b0);
    idle(3);
    rst = 1'b1; step(); rst = 1'b0; step();

    // in_valid in IDLE: discarded and flagged, cleared by the next start.
    in_data = 48'h000000001280;
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    chk("overrun_set", 64'(err_overrun), 64'(1));
    chk("overrun_no_wr", 64'(wr_en), 64'(0));
    start = 1'b1; step(); start = 1'b0;
    chk("overrun_clear", 64'(err_overrun), 64'(0));
    chk("busy_layer", 64'(busy), 64'(1));

    // Full continuous layer; a stray start mid-layer must be ignored.
    sat_exp = 0;
    hwc_en = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      start = (i == 1000) ? 1'b1 : 1'b0;
      drive_sample(rand_val(i), 15'(i));
    end
    in_valid = 1'b0; start = 1'b0;
    chk("flush_busy", 64'(busy), 64'(1));
    chk("flush_done", 64'(done), 64'(0));
    step();
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_wr_en", 64'(wr_en), 64'(1));
    step();
    chk("done_low", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("layer_sat_cnt", 64'(sat_cnt), 64'(sat_exp));
    chk("layer_overrun", 64'(err_overrun), 64'(0));
    idle(3);
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    chk("hwc_count", 64'(hwc_idx), 64'(32768));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
